// File: rtl/alu_op_driver_pkg.sv
// Shared opcode, flag and state definitions for the ALU command driver.
// The opcode list doubles as the set of legal selects.
package alu_op_driver_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  localparam int FLG_Z   = 3;
  localparam int FLG_O   = 2;
  localparam int FLG_CA  = 1;
  localparam int FLG_NEG = 0;

  typedef struct packed {
    logic z;
    logic o;
    logic ca;
    logic neg;
  } alu_flags_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // 0110 and 1011..1111 are unassigned; the ALU answers them with A^B.
  function automatic logic is_legal_op(input logic [3:0] sel);
    case (sel)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// Command and response handshakes between the stimulus side and the ALU driver.
interface alu_op_driver_if #(parameter int N = 6);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [3:0]   cmd_sel;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_out;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_op_driver.sv
// Registers one ALU operation, holds it for SETTLE cycles, captures the ALU
// result/flags and returns them; also keeps sticky flags and an op count.
module alu_op_driver
  import alu_op_driver_pkg::*;
#(
  parameter int N      = 6,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_driver_if.slave    bus,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [3:0]        alu_sel,
  input  logic [N-1:0]      alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        sticky_flags,
  input  logic              clr_sticky,
  output logic [7:0]        op_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [N-1:0] rsp_out_q;
  logic [3:0]   rsp_flags_q;
  logic         rsp_err_q;
  logic         accept;
  logic         capture;

  assign accept  = (state == ST_IDLE) && bus.cmd_valid;
  assign capture = (state == ST_DRIVE) && (cnt == SETTLE_LAST);

  // cmd_ready is gated by rst_n so nothing looks acceptable while reset is held.
  assign bus.cmd_ready = (state == ST_IDLE) && rst_n;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cnt   <= '0;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt == SETTLE_LAST) state <= ST_RESP;
          else                    cnt   <= cnt + 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs only move on acceptance, so they are stable through DRIVE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      alu_a   <= bus.cmd_a;
      alu_b   <= bus.cmd_b;
      alu_sel <= bus.cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      op_count    <= '0;
    end else if (capture) begin
      rsp_out_q   <= alu_out;
      rsp_flags_q <= alu_flags;
      rsp_err_q   <= !is_legal_op(alu_sel);
      op_count    <= op_count + 8'd1;
    end
  end

  // A clear coinciding with a capture keeps only the newly captured flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (capture) begin
      sticky_flags <= alu_flags | (clr_sticky ? 4'b0000 : sticky_flags);
    end else if (clr_sticky) begin
      sticky_flags <= '0;
    end
  end

endmodule
